// File: rtl/gb_timer_pkg.sv
// Shared constants and types for the gb_timer divider/timer block.
package gb_timer_pkg;

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  typedef enum logic [1:0] {
    SEL_4K   = 2'b00,
    SEL_262K = 2'b01,
    SEL_65K  = 2'b10,
    SEL_16K  = 2'b11
  } tac_sel_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OVF  = 1'b1
  } tmr_state_t;

  // Divider bit whose falling edge clocks TIMA for a given TAC rate select.
  function automatic logic [3:0] tap_index(input tac_sel_t sel);
    tap_index = 4'd9;
    case (sel)
      SEL_4K:   tap_index = 4'd9;
      SEL_262K: tap_index = 4'd3;
      SEL_65K:  tap_index = 4'd5;
      SEL_16K:  tap_index = 4'd7;
      default:  tap_index = 4'd9;
    endcase
  endfunction

endpackage

// File: rtl/timer_fall_detect.sv
// Registered falling-edge detector; a suppressed cycle blanks the edge seen right after it.
module timer_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  input  logic i_suppress,
  output logic o_fall
);

  logic r_prev;
  logic r_supp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev <= 1'b0;
      r_supp <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_supp <= i_suppress;
    end
  end

  assign o_fall = r_prev & ~i_sig & ~r_supp;

endmodule

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer with delayed overflow reload.
// Define GB_TIMER_GLITCH_EN to let DIV/TAC writes produce DMG-style spurious ticks.
module gb_timer
  import gb_timer_pkg::*;
#(
  parameter int OVF_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] addr,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_timer
);

  localparam int CW = (OVF_DELAY > 1) ? $clog2(OVF_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(OVF_DELAY - 1);

  logic [15:0]   r_div;
  logic [7:0]    r_tima;
  logic [7:0]    r_tma;
  logic [2:0]    r_tac;
  tmr_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_irq;

  logic [15:0]   w_div_next;
  logic [7:0]    w_tima_next;
  logic [7:0]    w_tma_next;
  logic [2:0]    w_tac_next;
  tmr_state_t    w_state_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_irq_next;

  logic       w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
  logic [3:0] w_tap;
  logic       w_sig, w_suppress, w_fall;

  assign w_wr_div  = wr & (addr == ADDR_DIV);
  assign w_wr_tima = wr & (addr == ADDR_TIMA);
  assign w_wr_tma  = wr & (addr == ADDR_TMA);
  assign w_wr_tac  = wr & (addr == ADDR_TAC);

  assign w_tap = tap_index(tac_sel_t'(r_tac[1:0]));
  assign w_sig = r_tac[2] & r_div[w_tap];

`ifdef GB_TIMER_GLITCH_EN
  assign w_suppress = 1'b0;
`else
  // Edges caused by register writes must not count; only divider rollover may tick.
  assign w_suppress = w_wr_div | w_wr_tac;
`endif

  timer_fall_detect u_fall (
    .clk        (clk),
    .reset      (reset),
    .i_sig      (w_sig),
    .i_suppress (w_suppress),
    .o_fall     (w_fall)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div   <= 16'h0000;
      r_tima  <= 8'h00;
      r_tma   <= 8'h00;
      r_tac   <= 3'b000;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_div   <= w_div_next;
      r_tima  <= w_tima_next;
      r_tma   <= w_tma_next;
      r_tac   <= w_tac_next;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_irq   <= w_irq_next;
    end
  end

  always_comb begin
    w_div_next   = w_wr_div ? 16'h0000 : r_div + 16'h0001;
    w_tma_next   = w_wr_tma ? din : r_tma;
    w_tac_next   = w_wr_tac ? din[2:0] : r_tac;
    w_tima_next  = r_tima;
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_irq_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_tima) begin
          w_tima_next = din;
        end else if (w_fall) begin
          if (r_tima == 8'hFF) begin
            w_tima_next  = 8'h00;
            w_state_next = ST_OVF;
            w_cnt_next   = CNT_LOAD;
          end else begin
            w_tima_next = r_tima + 8'h01;
          end
        end
      end
      ST_OVF: begin
        // On the reload cycle a same-cycle TMA write feeds straight through.
        if (r_cnt == '0) begin
          w_tima_next  = w_tma_next;
          w_irq_next   = 1'b1;
          w_state_next = ST_IDLE;
        end else if (w_wr_tima) begin
          w_tima_next  = din;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      ADDR_DIV:  dout = r_div[15:8];
      ADDR_TIMA: dout = r_tima;
      ADDR_TMA:  dout = r_tma;
      ADDR_TAC:  dout = {5'b11111, r_tac};
      default:   dout = 8'h00;
    endcase
  end

  assign irq_timer = r_irq;

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer: register table plus overflow, cancel, glitch and reset sequences.
module tb_gb_timer;
  import gb_timer_pkg::*;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq_timer;

  int checks = 0;
  int errors = 0;
  int pc;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  gb_timer #(.OVF_DELAY(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wr        (wr),
    .din       (din),
    .dout      (dout),
    .irq_timer (irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since the last reset release: pc == k right after posedge Pk.
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 0;
    else        pc <= pc + 1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc=%0d)", name, act, exp, pc);
    end else begin
      $display("ok   %s: %h (pc=%0d)", name, act, pc);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = dout;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, v);
    chk(name, v, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {7'd0, irq_timer}, {7'd0, exp});
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    addr = a;
    din  = d;
    wr   = 1'b1;
    @(negedge clk);
    wr   = 1'b0;
  endtask

  task automatic wait_pc(input int n);
    for (int i = 0; i < 2000 && pc < n; i++) @(negedge clk);
    if (pc != n) begin
      errors++;
      $display("FAIL wait_pc: at %0d wanted %0d", pc, n);
    end
  endtask

  task automatic do_reset();
    wr    = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // TIMA=FE, TMA=A0, TAC=05 written at P1..P3; overflow lands at P33.
  task automatic ovf_prefix();
    do_reset();
    wr_reg(ADDR_TIMA, 8'hFE);
    wr_reg(ADDR_TMA,  8'hA0);
    wr_reg(ADDR_TAC,  8'h05);
    wait_pc(33);
  endtask

  initial begin
    vecs[0] = '{ADDR_TMA,  8'h5A, 8'h5A};
    vecs[1] = '{ADDR_TAC,  8'h03, 8'hFB};
    vecs[2] = '{ADDR_TAC,  8'h1A, 8'hFA};
    vecs[3] = '{ADDR_TAC,  8'hF8, 8'hF8};
    vecs[4] = '{ADDR_TIMA, 8'hC3, 8'hC3};
    vecs[5] = '{ADDR_TIMA, 8'hFF, 8'hFF};
    vecs[6] = '{ADDR_DIV,  8'hAB, 8'h00};
    vecs[7] = '{ADDR_TMA,  8'h00, 8'h00};

    reset = 1'b0;
    wr    = 1'b0;
    addr  = 2'd0;
    din   = 8'h00;
    repeat (2) @(negedge clk);
    chk_reg("rst_div",  ADDR_DIV,  8'h00);
    chk_reg("rst_tima", ADDR_TIMA, 8'h00);
    chk_reg("rst_tma",  ADDR_TMA,  8'h00);
    chk_reg("rst_tac",  ADDR_TAC,  8'hF8);
    chk_irq("rst_irq", 1'b0);
    reset = 1'b1;

    // Free-running count with the 262 kHz tap
    wr_reg(ADDR_TAC, 8'h05);
    wait_pc(16);  chk_reg("cnt_p16_tima",  ADDR_TIMA, 8'h00);
    wait_pc(17);  chk_reg("cnt_p17_tima",  ADDR_TIMA, 8'h01);
    wait_pc(256); chk_reg("cnt_p256_div",  ADDR_DIV,  8'h01);
                  chk_reg("cnt_p256_tima", ADDR_TIMA, 8'h0F);
    wait_pc(257); chk_reg("cnt_p257_tima", ADDR_TIMA, 8'h10);

    // Register table with the timer disabled
    do_reset();
    for (int i = 0; i < 8; i++) begin
      wr_reg(vecs[i].a, vecs[i].d);
      chk_reg($sformatf("vec%0d", i), vecs[i].a, vecs[i].exp);
    end

    // Normal overflow and delayed reload
    do_reset();
    wr_reg(ADDR_TIMA, 8'hFE);
    wr_reg(ADDR_TMA,  8'hA0);
    wr_reg(ADDR_TAC,  8'h05);
    wait_pc(17); chk_reg("ovf_p17_tima", ADDR_TIMA, 8'hFF);
    wait_pc(32); chk_reg("ovf_p32_tima", ADDR_TIMA, 8'hFF);
    for (int k = 33; k <= 36; k++) begin
      wait_pc(k);
      chk_reg($sformatf("ovf_p%0d_tima", k), ADDR_TIMA, 8'h00);
      chk_irq($sformatf("ovf_p%0d_irq", k), 1'b0);
    end
    wait_pc(37); chk_reg("ovf_p37_tima", ADDR_TIMA, 8'hA0);
                 chk_irq("ovf_p37_irq", 1'b1);
    wait_pc(38); chk_reg("ovf_p38_tima", ADDR_TIMA, 8'hA0);
                 chk_irq("ovf_p38_irq", 1'b0);

    // TIMA write in the second delay cycle cancels reload and irq
    ovf_prefix();
    wait_pc(34);
    wr_reg(ADDR_TIMA, 8'h33);
    for (int k = 35; k <= 40; k++) begin
      wait_pc(k);
      chk_reg($sformatf("cancel_p%0d_tima", k), ADDR_TIMA, 8'h33);
      chk_irq($sformatf("cancel_p%0d_irq", k), 1'b0);
    end

    // TMA write on the reload cycle passes through to TIMA
    ovf_prefix();
    wait_pc(36);
    wr_reg(ADDR_TMA, 8'h77);
    chk_reg("tmawr_tima", ADDR_TIMA, 8'h77);
    chk_reg("tmawr_tma",  ADDR_TMA,  8'h77);
    chk_irq("tmawr_irq", 1'b1);
    wait_pc(38); chk_irq("tmawr_irq_off", 1'b0);

    // TIMA write on the reload cycle loses to TMA
    ovf_prefix();
    wait_pc(36);
    wr_reg(ADDR_TIMA, 8'h55);
    chk_reg("timawr_tima", ADDR_TIMA, 8'hA0);
    chk_irq("timawr_irq", 1'b1);

    // DIV write while the selected tap bit is high
    do_reset();
    wr_reg(ADDR_TIMA, 8'h40);
    wr_reg(ADDR_TAC,  8'h05);
    wait_pc(8);
    chk_reg("glitch_pre_tima", ADDR_TIMA, 8'h40);
    wr_reg(ADDR_DIV, 8'h5A);
    chk_reg("glitch_div", ADDR_DIV, 8'h00);
    wait_pc(10);
`ifdef GB_TIMER_GLITCH_EN
    chk_reg("glitch_p10_tima", ADDR_TIMA, 8'h41);
    wait_pc(12); chk_reg("glitch_p12_tima", ADDR_TIMA, 8'h41);
`else
    chk_reg("glitch_p10_tima", ADDR_TIMA, 8'h40);
    wait_pc(12); chk_reg("glitch_p12_tima", ADDR_TIMA, 8'h40);
`endif

    // Reset asserted mid-delay aborts the reload
    ovf_prefix();
    wait_pc(35);
    reset = 1'b0;
    @(negedge clk);
    chk_reg("midrst_div",  ADDR_DIV,  8'h00);
    chk_reg("midrst_tima", ADDR_TIMA, 8'h00);
    chk_reg("midrst_tma",  ADDR_TMA,  8'h00);
    chk_reg("midrst_tac",  ADDR_TAC,  8'hF8);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk_irq($sformatf("midrst_irq%0d", k), 1'b0);
    end
    chk_reg("midrst_tima_after", ADDR_TIMA, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy timer/divider unit: a free-running 16-bit system divider, exposed as DIV, and a programmable 8-bit counter TIMA with reload value TMA and control register TAC. It sits on the CPU I/O bus at FF04–FF07 and raises a one-cycle timer interrupt request toward the interrupt-flag logic. Overflow reload uses the hardware-accurate 4-cycle delay.

## Interface
Parameters:
- OVF_DELAY, 4, cycles from TIMA overflow to TMA reload and interrupt request.

Ports:
- clk  in  1  T-cycle clock, 4.194304 MHz.
- reset  in  1  asynchronous, active-low; clears all state while low.
- addr  in  2  register select: 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- wr  in  1  write strobe for one cycle, sampled at posedge clk.
- din  in  8  write data.
- dout  out  8  combinational read data for the register selected by addr.
- irq_timer  out  1  one-cycle pulse when TMA is reloaded after an overflow.

## Operation
- Divider: 16-bit `div` increments every cycle and wraps FFFF→0000. DIV reads `div[15:8]`. Any write to DIV clears all 16 bits, regardless of din.
- TAC: bit 2 is the enable; bits 1:0 select the tap: 00→div[9], 01→div[3], 10→div[5], 11→div[7]. Reads return `{5'b11111, tac[2:0]}`.
- Tick: `sig = tac[2] & div[tap]`. TIMA increments on the cycle after `sig` falls from 1 to 0.
- Overflow FSM, states IDLE and OVF:
  - IDLE→OVF when TIMA increments from FF. TIMA becomes 00, and an internal counter is loaded with OVF_DELAY-1.
  - In OVF, the counter decrements each cycle. When it reaches 0: TIMA←TMA, irq_timer=1 for that cycle, return to IDLE.
  - A TIMA write while in OVF, other than on the reload cycle, cancels the reload and the irq. TIMA takes din, return to IDLE.
  - A TIMA write on the reload cycle is ignored; TMA wins.
  - A TMA write on the reload cycle: TIMA takes the new din value.
- TIMA write in IDLE: TIMA←din. If a tick coincides with the write, the write wins.
- TMA write: TMA←din. Reads return the stored value.
- Reset values: div=0000, TIMA=00, TMA=00, TAC=000 (reads F8), state=IDLE, irq_timer=0.

## Timing
- Register writes take effect at the posedge where wr=1 and are visible on dout the next cycle.
- Tick latency: a `sig` falling edge at posedge N produces the TIMA increment at posedge N+1.
- Overflow: TIMA=FF plus a tick at posedge N gives TIMA=00 for posedges N..N+OVF_DELAY-1. Reload happens at posedge N+OVF_DELAY; irq_timer is high during that cycle only.
- A tick arriving while in OVF is ignored; TIMA stays 00.
- Reset asserted mid-OVF: the reload is aborted and no irq fires.

## Configuration
- GB_TIMER_GLITCH_EN defined: `sig` is evaluated continuously. A DIV write that clears a high tap bit, a TAC write that clears the enable, or a tap change from a high bit to a low bit each produces a falling edge, so TIMA increments once, matching DMG hardware.
- Not defined: only divider counting can produce ticks. An edge caused by a DIV or TAC write is suppressed for that cycle.

## Structure
- Package `gb_timer_pkg`:
  - address constants ADDR_DIV, ADDR_TIMA, ADDR_TMA, ADDR_TAC;
  - enum `tac_sel_t` (SEL_4K, SEL_262K, SEL_65K, SEL_16K);
  - tap-index function;
  - FSM state enum `tmr_state_t`.
- One sub-module, `timer_fall_detect`: a registered falling-edge detector with a suppress input. The suppress input is tied low when GB_TIMER_GLITCH_EN is defined.

## Test plan
- Reset release, TAC=05, TIMA=00 → TIMA=01 after 16 cycles and 10 after 256 cycles; DIV reads 01 after 256 cycles.
- TIMA=FE, TMA=A0, TAC=05 → after 2 ticks TIMA=00 for 4 cycles, then A0 with irq_timer high for exactly 1 cycle.
- Overflow, then write TIMA=33 in the 2nd delay cycle → TIMA=33, no irq, TMA not loaded.
- Overflow, then write TMA=77 on the reload cycle → TIMA=77 and irq pulses once.
- With div[3]=1, TAC=05, write DIV → GB_TIMER_GLITCH_EN defined: TIMA +1 and DIV=00; not defined: TIMA unchanged.
- Assert reset during the OVF delay → all registers 0, dout for TAC=F8, no irq after release.
